// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared constants and helpers for the scoreboard digit source
package scoreboard_pkg;
  localparam logic [1:0] RDEN_NONE = 2'b00;
  localparam logic [1:0] RDEN_TENS = 2'b01;
  localparam logic [1:0] RDEN_ONES = 2'b10;
  localparam int GLYPH_AW = 10;
  localparam int DEF_DIGIT_W = 32;
  localparam int DEF_DIGIT_H = 32;
  localparam int DEF_TENS_X0 = 560;
  localparam int DEF_ONES_X0 = 596;
  localparam int DEF_DIGIT_Y0 = 8;
  localparam int DEF_PIX_W = 11;
  function automatic logic [9:0] onehot10(input logic [3:0] d);
    return 10'(1) << d;
  endfunction
endpackage

// File: rtl/score_bcd_counter.sv
// score_bcd_counter: two-digit BCD score with clamped hits, saturation at 99 and clear priority
module score_bcd_counter
  import scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       hit,
  input  logic [3:0] points,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [6:0] score_bin,
  output logic       saturated
);
  logic [3:0] p, nt, nx_o, nx_t;
  logic [4:0] s;
  logic       carry, ovf;
  always_comb begin
    p = points > 4'd9 ? 4'd9 : points;
    s = 5'(ones) + 5'(p);
    carry = s >= 5'd10;
    nt = tens + 4'(carry);
    ovf = nt >= 4'd10;
    nx_o = ovf ? 4'd9 : carry ? 4'(s - 5'd10) : s[3:0];
    nx_t = ovf ? 4'd9 : nt;
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ones <= '0;
      tens <= '0;
      score_bin <= '0;
      saturated <= 1'b0;
    end else if (hit && !saturated) begin
      ones <= nx_o;
      tens <= nx_t;
      score_bin <= 7'(nx_t * 10 + nx_o);
      saturated <= nx_o == 4'd9 && nx_t == 4'd9;
    end
  end
endmodule

// File: rtl/scoreboard_digit_source.sv
// scoreboard_digit_source: score keeping, frame-latched one-hot digits and glyph address generation
module scoreboard_digit_source
  import scoreboard_pkg::*;
#(
  parameter int DIGIT_W  = DEF_DIGIT_W,
  parameter int DIGIT_H  = DEF_DIGIT_H,
  parameter int TENS_X0  = DEF_TENS_X0,
  parameter int ONES_X0  = DEF_ONES_X0,
  parameter int DIGIT_Y0 = DEF_DIGIT_Y0,
  parameter int PIX_W    = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             hit,
  input  logic [3:0]       points,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_x,
  input  logic [PIX_W-1:0] pix_y,
  output logic [9:0]       onehot_ones,
  output logic [9:0]       onehot_tens,
  output logic [19:0]      addr_out,
  output logic [1:0]       rden,
  output logic [6:0]       score_bin,
  output logic             saturated
);
  localparam logic [PIX_W-1:0] TX0 = PIX_W'(TENS_X0);
  localparam logic [PIX_W-1:0] TX1 = PIX_W'(TENS_X0 + DIGIT_W);
  localparam logic [PIX_W-1:0] OX0 = PIX_W'(ONES_X0);
  localparam logic [PIX_W-1:0] OX1 = PIX_W'(ONES_X0 + DIGIT_W);
  localparam logic [PIX_W-1:0] Y0  = PIX_W'(DIGIT_Y0);
  localparam logic [PIX_W-1:0] Y1  = PIX_W'(DIGIT_Y0 + DIGIT_H);
  logic [3:0] ones, tens;
  logic in_y, in_t, in_o;
  logic [PIX_W-1:0] dy, dxt, dxo;
  logic [GLYPH_AW-1:0] ta, oa;
  score_bcd_counter u_cnt (
    .clk(clk), .rst(rst), .clear(clear), .hit(hit), .points(points),
    .ones(ones), .tens(tens), .score_bin(score_bin), .saturated(saturated)
  );
  always_comb begin
    in_y = pix_y >= Y0 && pix_y < Y1;
    in_t = pix_valid && in_y && pix_x >= TX0 && pix_x < TX1;
    in_o = pix_valid && in_y && pix_x >= OX0 && pix_x < OX1;
    dy = pix_y - Y0;
    dxt = pix_x - TX0;
    dxo = pix_x - OX0;
    ta = GLYPH_AW'(dy * DIGIT_W + dxt);
    oa = GLYPH_AW'(dy * DIGIT_W + dxo);
  end
  // shadow sees the pre-hit digits because the counter updates on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      onehot_ones <= 10'b1;
      onehot_tens <= 10'b1;
      addr_out <= '0;
      rden <= RDEN_NONE;
    end else begin
      if (frame_start) begin
        onehot_ones <= onehot10(ones);
        onehot_tens <= onehot10(tens);
      end
      rden <= in_t ? RDEN_TENS : in_o ? RDEN_ONES : RDEN_NONE;
      if (in_t) addr_out[9:0] <= ta;
      else if (in_o) addr_out[19:10] <= oa;
    end
  end
endmodule

// File: tb/tb_scoreboard_digit_source.sv
// tb_scoreboard_digit_source: directed table and sequence checks for scoreboard_digit_source
module tb_scoreboard_digit_source;
  logic clk = 0, rst = 1, clear = 0, hit = 0, frame_start = 0, pix_valid = 0;
  logic [3:0] points = 0;
  logic [10:0] pix_x = 0, pix_y = 0;
  logic [9:0] onehot_ones, onehot_tens;
  logic [19:0] addr_out;
  logic [1:0] rden;
  logic [6:0] score_bin;
  logic saturated;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic v; int x; int y; logic [1:0] er; logic [19:0] ea;
  } pix_vec_t;
  pix_vec_t pv[10];

  scoreboard_digit_source dut (
    .clk(clk), .rst(rst), .clear(clear), .hit(hit), .points(points),
    .frame_start(frame_start), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .onehot_ones(onehot_ones), .onehot_tens(onehot_tens), .addr_out(addr_out),
    .rden(rden), .score_bin(score_bin), .saturated(saturated)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_hit(input logic [3:0] p);
    hit = 1; points = p;
    tick;
    hit = 0; points = 0;
  endtask

  task automatic do_frame;
    frame_start = 1;
    tick;
    frame_start = 0;
  endtask

  initial begin
    pv[0] = '{1, 563, 10, 2'b01, 20'd67};
    pv[1] = '{1, 627, 39, 2'b10, 20'd1047619};
    pv[2] = '{1, 592, 10, 2'b00, 20'd1047619};
    pv[3] = '{0, 600, 20, 2'b00, 20'd1047619};
    pv[4] = '{1, 560, 8, 2'b01, 20'd1047552};
    pv[5] = '{1, 601, 9, 2'b10, 20'd37888};
    pv[6] = '{1, 559, 10, 2'b00, 20'd37888};
    pv[7] = '{1, 591, 39, 2'b01, 20'd38911};
    pv[8] = '{1, 627, 40, 2'b00, 20'd38911};
    pv[9] = '{1, 600, 7, 2'b00, 20'd38911};

    tick; tick;
    rst = 0;
    check("reset_score", 32'(score_bin), 0);
    check("reset_sat", 32'(saturated), 0);
    check("reset_rden", 32'(rden), 0);
    check("reset_addr", 32'(addr_out), 0);
    do_frame;
    check("frame0_ones", 32'(onehot_ones), 32'h001);
    check("frame0_tens", 32'(onehot_tens), 32'h001);

    hit = 1; points = 7; tick; tick; hit = 0; points = 0;
    check("b2b_score", 32'(score_bin), 14);
    check("pre_frame_ones", 32'(onehot_ones), 32'h001);
    do_frame;
    check("frame14_tens", 32'(onehot_tens), 32'h002);
    check("frame14_ones", 32'(onehot_ones), 32'h010);

    hit = 1; points = 1; frame_start = 1; tick; hit = 0; points = 0; frame_start = 0;
    check("fs_hit_score", 32'(score_bin), 15);
    check("fs_hit_ones", 32'(onehot_ones), 32'h010);
    do_frame;
    check("frame15_ones", 32'(onehot_ones), 32'h020);

    clear = 1; tick; clear = 0;
    check("clear_score", 32'(score_bin), 0);
    do_hit(9); do_hit(1);
    check("carry_10", 32'(score_bin), 10);
    clear = 1; tick; clear = 0;
    for (int i = 0; i < 10; i++) do_hit(9);
    do_hit(5);
    check("score95", 32'(score_bin), 95);
    check("sat95", 32'(saturated), 0);
    do_hit(9);
    check("sat_score", 32'(score_bin), 99);
    check("sat_flag", 32'(saturated), 1);
    do_hit(3);
    check("sat_hold", 32'(score_bin), 99);
    do_frame;
    check("frame99_ones", 32'(onehot_ones), 32'h200);
    check("frame99_tens", 32'(onehot_tens), 32'h200);
    clear = 1; hit = 1; points = 5; tick; clear = 0; hit = 0; points = 0;
    check("clear_prio_score", 32'(score_bin), 0);
    check("clear_prio_sat", 32'(saturated), 0);
    do_hit(15);
    check("clamp15", 32'(score_bin), 9);
    do_hit(0);
    check("zero_pts", 32'(score_bin), 9);

    for (int i = 0; i < 10; i++) begin
      pix_valid = pv[i].v; pix_x = 11'(pv[i].x); pix_y = 11'(pv[i].y);
      tick;
      check($sformatf("pix%0d_rden", i), 32'(rden), 32'(pv[i].er));
      check($sformatf("pix%0d_addr", i), 32'(addr_out), 32'(pv[i].ea));
    end
    pix_valid = 0;

    do_frame;
    check("pre_rst_ones", 32'(onehot_ones), 32'h200);
    rst = 1; tick; rst = 0;
    check("midrst_ones", 32'(onehot_ones), 32'h001);
    check("midrst_addr", 32'(addr_out), 0);
    check("midrst_score", 32'(score_bin), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
